id_stage_param: RTL and testbench
=================================

# id_stage_param

Parametrised decode stage for the five-stage MIPS-R2000 pipeline, sitting between IF and EX. It holds the register file and decodes the main control fields, and it resolves `beq`/`j` early in the stage. Load-use and branch-operand hazards are detected here and turned into a stall plus an EX bubble. Decoded operands, register indices and control bundles are registered into the ID/EX pipeline register, qualified by a valid bit.

## Interface
Parameters:
- `DATA_W`, 32, register and datapath width.
- `NREG`, 32, register count; register 0 is hardwired to zero.
- `REG_W`, `$clog2(NREG)`, register index width. Instruction fields stay 5 bits and are truncated or zero-extended to `REG_W`.
- `SIGN_EXT`, 1, selects the immediate extension: 1 sign-extends, 0 zero-extends.

Ports. One clock; reset is synchronous and active-high.
- `clk`, in, 1, clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous active-high reset.
- `if_valid`, in, 1, `inst_in` and `pc` hold a real instruction.
- `pc`, in, `DATA_W`, PC+4 of the instruction in ID.
- `inst_in`, in, 32, instruction word.
- `reg_write`, in, 1, WB write enable.
- `write_register`, in, `REG_W`, WB destination.
- `write_data_reg`, in, `DATA_W`, WB data.
- `mem_reg_write`, in, 1, the MEM-stage instruction will write a register.
- `mem_write_register`, in, `REG_W`, the MEM-stage destination.
- `stall`, out, 1, hold PC and IF/ID this cycle (combinational).
- `br`, out, 1, a taken `beq` or a `j` is in ID (combinational).
- `pc_branch`, out, `DATA_W`, redirect target (combinational).
- `exception`, out, 1, unknown opcode in a valid slot (combinational).
- `valid`, out, 1, ID/EX holds a real instruction.
- `rs`, `rt`, `rd`, out, `REG_W` each, registered indices.
- `imm`, out, `DATA_W`, registered extended immediate.
- `data_1`, `data_2`, out, `DATA_W` each, registered operands.
- `ex`, out, 4, `{RegDst, ALUOp1, ALUOp0, ALUSrc}`.
- `m`, out, 3, `{Branch, MemRead, MemWrite}`.
- `wb`, out, 2, `{RegWrite, MemtoReg}`.

## Operation
- **Register file.** `NREG` x `DATA_W`.
  - Written at the rising edge when `reg_write` is high and `write_register` is not 0. Writes to register 0 are ignored.
  - Reads are combinational. If a read index equals `write_register` while `reg_write` is high and the index is not 0, the read returns `write_data_reg` (write-before-read bypass).
- **Decode.** Don't-care bits resolve to 0.
  - Opcode 0 (R-type): ex=1100, m=000, wb=10.
  - Opcode 100011 (lw): ex=0001, m=010, wb=11.
  - Opcode 101011 (sw): ex=0001, m=001, wb=00.
  - Opcode 000100 (beq): ex=0010, m=100, wb=00.
  - Opcode 000010 (j): ex=0000, m=000, wb=00.
  - Any other opcode: all control fields zero and `exception`=`if_valid`.
- **EX destination.** The destination of the instruction in EX is `rd` if `ex[3]` is set, else `rt`. It is live only when `valid & wb[1]` and the destination is not 0.
- **Load-use stall.** Raised when `valid & m[1]` and the EX `rt` equals the decoding instruction's rs, or its rt for R-type, beq and sw.
- **Branch stall.** Raised when the ID instruction is a valid `beq` and rs or rt matches either of:
  - the live EX destination;
  - `mem_write_register` with `mem_reg_write` high and the index not 0.
- **Stall.** `stall` is the OR of the two stall terms, gated by `if_valid`.
- **Branch and jump outcome.** `br` is 1 in two cases, both requiring `!stall`:
  - `beq & if_valid` with equal bypassed operands; `pc_branch` = `pc + (imm << 2)`, where `imm` follows `SIGN_EXT`.
  - `j & if_valid`; `pc_branch` = `{pc[DATA_W-1:28], inst_in[25:0], 2'b00}`.
- **Flush.** IF flushes IF/ID when `br` is high. This block takes no flush input.
- **ID/EX update** at each rising edge:
  - When `stall` is high, a bubble is loaded: `valid`, `ex`, `m` and `wb` are set to 0, and the other fields are don't-care (loaded with the current values).
  - Otherwise all fields load from decode and `valid` takes `if_valid`.
  - When `if_valid` is 0, the control fields are forced to 0.

## Timing
- **Reset.** With `rst` high at a clock edge:
  - all ID/EX outputs go to 0, including `valid`;
  - all registers in the register file are cleared to 0 in that single cycle.
- **Reset precedence.** `rst` overrides a simultaneous write. A reset mid-stall drops the stalled instruction, since IF re-fetches it.
- **Latency.** Decode to ID/EX is one cycle. `stall`, `br`, `pc_branch` and `exception` are same-cycle combinational outputs.
- **Stall length.**
  - Load-use: exactly one cycle; the following cycle sees a bubble in EX.
  - Branch: up to two cycles while the dependency moves from EX to MEM to WB. On the third cycle WB bypass supplies the value.
- **Simultaneous events.** A stall and an equal-operand beq in the same cycle give `br`=0. The branch re-evaluates once the stall clears.

## Structure
- Shared package `mips_pkg`: opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`) and packed typedefs for the `ex`, `m` and `wb` bundles. Both the control and hazard logic use them.
- Sub-module `regfile_param`: `DATA_W` and `NREG` parameters, two read ports, one write port, WB bypass and synchronous clear. Decode, hazard logic and the ID/EX register stay in `id_stage_param`.

## Test plan
- **WB bypass.** Write 0xDEADBEEF to r5 while decoding `add r1,r5,r6` -> next cycle `data_1`=0xDEADBEEF. Write to r0 -> `data_1` stays 0.
- **Load-use.** `lw r2,0(r3)` in EX, then `add r4,r2,r2` in ID -> `stall`=1 for one cycle. Bubble: `valid`=0, ex=m=wb=0. The add enters EX on the next cycle.
- **Branch.** `beq r1,r1,-1` with `pc`=0x100 -> `br`=1, `pc_branch`=0xFC.
  - With `SIGN_EXT`=0 and imm=0xFFFF -> `pc_branch`=0x100+0x3FFFC.
- **Branch hazard.** `add r7,...` in EX, then `beq r7,r0` -> two stall cycles, as the dependency passes EX and then MEM via the mem_ inputs. `br` resolves on the third cycle.
- **Exception.** Opcode 111111 with `if_valid`=1 -> `exception`=1 and ex=m=wb=0 loaded. With `if_valid`=0 -> `exception`=0.
- **Reset.** Assert `rst` mid-stall with `reg_write` high -> outputs 0, regfile cleared, the write is discarded. `NREG`=16 and `DATA_W`=64 build passes the same checks.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode constants, control-bundle types and the main
// control decoder for the MIPS-R2000 decode stage.
//   OP_*          : primary opcode values understood by the decoder
//   ex_ctrl_t     : {RegDst, ALUOp1, ALUOp0, ALUSrc}
//   m_ctrl_t      : {Branch, MemRead, MemWrite}
//   wb_ctrl_t     : {RegWrite, MemtoReg}
//   decode_op()   : opcode -> control bundles plus a "known opcode" flag
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic reg_dst;
    logic alu_op1;
    logic alu_op0;
    logic alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    m_ctrl_t  m;
    wb_ctrl_t wb;
    logic     known;
  } ctrl_t;

  // Main control table; unknown opcodes yield all-zero controls with known=0.
  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.ex = 4'b1100; c.m = 3'b000; c.wb = 2'b10; c.known = 1'b1;
      end
      OP_LW: begin
        c.ex = 4'b0001; c.m = 3'b010; c.wb = 2'b11; c.known = 1'b1;
      end
      OP_SW: begin
        c.ex = 4'b0001; c.m = 3'b001; c.wb = 2'b00; c.known = 1'b1;
      end
      OP_BEQ: begin
        c.ex = 4'b0010; c.m = 3'b100; c.wb = 2'b00; c.known = 1'b1;
      end
      OP_J: begin
        c.ex = 4'b0000; c.m = 3'b000; c.wb = 2'b00; c.known = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_param_if.sv
// id_stage_param_if: bundle of all non-clock signals of the decode stage.
//   Fetch side   : if_valid, pc (PC+4), inst_in
//   WB side      : reg_write, write_register, write_data_reg
//   MEM side     : mem_reg_write, mem_write_register
//   Combinational: stall, br, pc_branch, exception
//   ID/EX reg    : valid, rs, rt, rd, imm, data_1, data_2, ex, m, wb
// master = the surrounding pipeline, slave = the decode stage.
interface id_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  logic              if_valid;
  logic [DATA_W-1:0] pc;
  logic [31:0]       inst_in;
  logic              reg_write;
  logic [REG_W-1:0]  write_register;
  logic [DATA_W-1:0] write_data_reg;
  logic              mem_reg_write;
  logic [REG_W-1:0]  mem_write_register;

  logic              stall;
  logic              br;
  logic [DATA_W-1:0] pc_branch;
  logic              exception;

  logic              valid;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [3:0]        ex;
  logic [2:0]        m;
  logic [1:0]        wb;

  modport master (
    output if_valid, pc, inst_in, reg_write, write_register, write_data_reg,
           mem_reg_write, mem_write_register,
    input  stall, br, pc_branch, exception,
           valid, rs, rt, rd, imm, data_1, data_2, ex, m, wb
  );

  modport slave (
    input  if_valid, pc, inst_in, reg_write, write_register, write_data_reg,
           mem_reg_write, mem_write_register,
    output stall, br, pc_branch, exception,
           valid, rs, rt, rd, imm, data_1, data_2, ex, m, wb
  );

endinterface

// File: rtl/regfile_param.sv
// regfile_param: NREG x DATA_W register file, register 0 reads as zero.
//   clk, rst   : clock, synchronous active-high clear of every register
//   ra1/rd1    : read port 1 (combinational)
//   ra2/rd2    : read port 2 (combinational)
//   we, wa, wd : write port, applied at the rising edge
// A read of the register being written this cycle returns wd directly.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ra1,
  input  logic [REG_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [NREG-1:0][DATA_W-1:0] regs;

  // Storage update: reset clears everything and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read port 1 with r0 forced to zero and WB bypass.
  always_comb begin
    rd1 = '0;
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (ra1 == wa)) begin
      rd1 = wd;
    end else begin
      rd1 = regs[ra1];
    end
  end

  // Read port 2 with r0 forced to zero and WB bypass.
  always_comb begin
    rd2 = '0;
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && (ra2 == wa)) begin
      rd2 = wd;
    end else begin
      rd2 = regs[ra2];
    end
  end

endmodule

// File: rtl/id_stage_param.sv
// id_stage_param: MIPS-R2000 decode stage with early beq/j resolution,
// load-use and branch-operand hazard detection, and the ID/EX register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_stage_param_if.slave (fetch, WB, MEM inputs; stall/br/
//              pc_branch/exception combinational outputs; ID/EX outputs)
// Assumes DATA_W >= 32 (jump target keeps pc[DATA_W-1:28]).
module id_stage_param
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int REG_W    = $clog2(NREG),
  parameter int SIGN_EXT = 1
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_param_if.slave bus
);

  // Instruction register fields are 5 bits; fit them to REG_W by
  // zero-extending through a wide temporary and keeping the low bits.
  function automatic logic [REG_W-1:0] fit_idx(input logic [4:0] f);
    logic [REG_W+4:0] t;
    t = {{REG_W{1'b0}}, f};
    return t[REG_W-1:0];
  endfunction

  logic [5:0]        opcode;
  logic [15:0]       imm16;
  logic [REG_W-1:0]  rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0] imm_ext, rd1, rd2, br_target, j_target;
  ctrl_t             ctrl;
  logic              is_rtype, is_beq, is_sw, is_j, uses_rt;

  logic [REG_W-1:0]  ex_dst;
  logic              ex_live, mem_live, load_use, br_hazard;
  logic              stall_int, br_int;
  logic [DATA_W-1:0] pc_branch_int;

  logic              valid_r;
  logic [REG_W-1:0]  rs_r, rt_r, rd_r;
  logic [DATA_W-1:0] imm_r, data_1_r, data_2_r;
  ex_ctrl_t          ex_r;
  m_ctrl_t           m_r;
  wb_ctrl_t          wb_r;

  assign opcode   = bus.inst_in[31:26];
  assign imm16    = bus.inst_in[15:0];
  assign rs_idx   = fit_idx(bus.inst_in[25:21]);
  assign rt_idx   = fit_idx(bus.inst_in[20:16]);
  assign rd_idx   = fit_idx(bus.inst_in[15:11]);
  assign ctrl     = decode_op(opcode);
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_sw    = (opcode == OP_SW);
  assign is_j     = (opcode == OP_J);
  assign uses_rt  = is_rtype | is_beq | is_sw;

  // Immediate extension selected at elaboration time.
  always_comb begin
    imm_ext = '0;
    if (SIGN_EXT != 0) begin
      imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    end else begin
      imm_ext = {{(DATA_W-16){1'b0}}, imm16};
    end
  end

  assign br_target = bus.pc + {imm_ext[DATA_W-3:0], 2'b00};
  assign j_target  = {bus.pc[DATA_W-1:28], bus.inst_in[25:0], 2'b00};

  regfile_param #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_W  (REG_W)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs_idx),
    .ra2 (rt_idx),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (bus.reg_write),
    .wa  (bus.write_register),
    .wd  (bus.write_data_reg)
  );

  // Hazard terms. The EX destination only matters when it will really be
  // written, and r0 never creates a dependency.
  assign ex_dst    = ex_r.reg_dst ? rd_r : rt_r;
  assign ex_live   = valid_r & wb_r.reg_write & (ex_dst != '0);
  assign mem_live  = bus.mem_reg_write & (bus.mem_write_register != '0);
  assign load_use  = valid_r & m_r.mem_read &
                     ((rt_r == rs_idx) | (uses_rt & (rt_r == rt_idx)));
  assign br_hazard = is_beq &
                     ((ex_live  & ((ex_dst == rs_idx) | (ex_dst == rt_idx))) |
                      (mem_live & ((bus.mem_write_register == rs_idx) |
                                   (bus.mem_write_register == rt_idx))));
  assign stall_int = bus.if_valid & (load_use | br_hazard);

  // Early branch/jump resolution; a stalled beq waits for its operands.
  always_comb begin
    br_int        = 1'b0;
    pc_branch_int = br_target;
    if (bus.if_valid && !stall_int && is_j) begin
      br_int        = 1'b1;
      pc_branch_int = j_target;
    end else if (bus.if_valid && !stall_int && is_beq && (rd1 == rd2)) begin
      br_int        = 1'b1;
      pc_branch_int = br_target;
    end else begin
      br_int        = 1'b0;
      pc_branch_int = is_j ? j_target : br_target;
    end
  end

  // ID/EX pipeline register; a stall or an empty slot loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      rs_r     <= '0;
      rt_r     <= '0;
      rd_r     <= '0;
      imm_r    <= '0;
      data_1_r <= '0;
      data_2_r <= '0;
      ex_r     <= '0;
      m_r      <= '0;
      wb_r     <= '0;
    end else begin
      rs_r     <= rs_idx;
      rt_r     <= rt_idx;
      rd_r     <= rd_idx;
      imm_r    <= imm_ext;
      data_1_r <= rd1;
      data_2_r <= rd2;
      if (stall_int || !bus.if_valid) begin
        valid_r <= 1'b0;
        ex_r    <= '0;
        m_r     <= '0;
        wb_r    <= '0;
      end else begin
        valid_r <= 1'b1;
        ex_r    <= ctrl.ex;
        m_r     <= ctrl.m;
        wb_r    <= ctrl.wb;
      end
    end
  end

  assign bus.stall     = stall_int;
  assign bus.br        = br_int;
  assign bus.pc_branch = pc_branch_int;
  assign bus.exception = bus.if_valid & ~ctrl.known;
  assign bus.valid     = valid_r;
  assign bus.rs        = rs_r;
  assign bus.rt        = rt_r;
  assign bus.rd        = rd_r;
  assign bus.imm       = imm_r;
  assign bus.data_1    = data_1_r;
  assign bus.data_2    = data_2_r;
  assign bus.ex        = ex_r;
  assign bus.m         = m_r;
  assign bus.wb        = wb_r;

endmodule

// File: tb/tb_id_stage_param.sv
// tb_id_stage_param: directed bench for id_stage_param. dut0 uses the
// default build (32x32, sign-extended immediates); dut1 uses NREG=16,
// DATA_W=64, zero-extended immediates. Expected ID/EX contents are queued
// when a step is driven and compared after the clock edge that loads them.
module tb_id_stage_param;
  import mips_pkg::*;

  typedef struct {
    logic        full;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [63:0] imm, d1, d2;
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t bub;

  localparam logic [63:0] DB   = 64'h00000000DEADBEEF;
  localparam logic [63:0] DB64 = 64'hDEADBEEF0BADF00D;

  always #5 clk = ~clk;

  id_stage_param_if #(.DATA_W(32), .REG_W(5)) if0 ();
  id_stage_param_if #(.DATA_W(64), .REG_W(4)) if1 ();

  id_stage_param #(.DATA_W(32), .NREG(32), .SIGN_EXT(1)) dut0 (
    .clk (clk), .rst (rst0), .bus (if0.slave)
  );
  id_stage_param #(.DATA_W(64), .NREG(16), .SIGN_EXT(0)) dut1 (
    .clk (clk), .rst (rst1), .bus (if1.slave)
  );

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd);
    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic full, valid, input logic [4:0] rs, rt, rd,
                              input logic [63:0] imm, d1, d2, input logic [3:0] ex,
                              input logic [2:0] m, input logic [1:0] wb);
    exp_t e;
    e.full = full; e.valid = valid; e.rs = rs; e.rt = rt; e.rd = rd;
    e.imm = imm; e.d1 = d1; e.d2 = d2; e.ex = ex; e.m = m; e.wb = wb;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one decode slot at the falling edge, check the combinational
  // outputs, then check the ID/EX contents loaded at the next rising edge.
  task automatic step(input int dut, input string tag, input logic r, input logic iv,
                      input logic [63:0] pcv, input logic [31:0] inst,
                      input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                      input logic mrw, input logic [4:0] mwr,
                      input logic es, input logic eb, input logic [63:0] epc,
                      input logic ee, input exp_t e);
    exp_t g;
    if (dut == 0) begin
      rst0 = r; if0.if_valid = iv; if0.pc = pcv[31:0]; if0.inst_in = inst;
      if0.reg_write = rw; if0.write_register = wr; if0.write_data_reg = wd[31:0];
      if0.mem_reg_write = mrw; if0.mem_write_register = mwr;
    end else begin
      rst1 = r; if1.if_valid = iv; if1.pc = pcv; if1.inst_in = inst;
      if1.reg_write = rw; if1.write_register = wr[3:0]; if1.write_data_reg = wd;
      if1.mem_reg_write = mrw; if1.mem_write_register = mwr[3:0];
    end
    sb.push_back(e);
    #1;
    if (dut == 0) begin
      chk({tag, ".stall"}, 64'(if0.stall), 64'(es));
      chk({tag, ".br"}, 64'(if0.br), 64'(eb));
      chk({tag, ".exception"}, 64'(if0.exception), 64'(ee));
      if (eb) chk({tag, ".pc_branch"}, 64'(if0.pc_branch), epc);
    end else begin
      chk({tag, ".stall"}, 64'(if1.stall), 64'(es));
      chk({tag, ".br"}, 64'(if1.br), 64'(eb));
      chk({tag, ".exception"}, 64'(if1.exception), 64'(ee));
      if (eb) chk({tag, ".pc_branch"}, if1.pc_branch, epc);
    end
    @(posedge clk);
    #1;
    g = sb.pop_front();
    if (dut == 0) begin
      chk({tag, ".valid"}, 64'(if0.valid), 64'(g.valid));
      chk({tag, ".ex"}, 64'(if0.ex), 64'(g.ex));
      chk({tag, ".m"}, 64'(if0.m), 64'(g.m));
      chk({tag, ".wb"}, 64'(if0.wb), 64'(g.wb));
      if (g.full) begin
        chk({tag, ".rs"}, 64'(if0.rs), 64'(g.rs));
        chk({tag, ".rt"}, 64'(if0.rt), 64'(g.rt));
        chk({tag, ".rd"}, 64'(if0.rd), 64'(g.rd));
        chk({tag, ".imm"}, 64'(if0.imm), g.imm);
        chk({tag, ".data_1"}, 64'(if0.data_1), g.d1);
        chk({tag, ".data_2"}, 64'(if0.data_2), g.d2);
      end
    end else begin
      chk({tag, ".valid"}, 64'(if1.valid), 64'(g.valid));
      chk({tag, ".ex"}, 64'(if1.ex), 64'(g.ex));
      chk({tag, ".m"}, 64'(if1.m), 64'(g.m));
      chk({tag, ".wb"}, 64'(if1.wb), 64'(g.wb));
      if (g.full) begin
        chk({tag, ".rs"}, 64'(if1.rs), 64'(g.rs[3:0]));
        chk({tag, ".rt"}, 64'(if1.rt), 64'(g.rt[3:0]));
        chk({tag, ".rd"}, 64'(if1.rd), 64'(g.rd[3:0]));
        chk({tag, ".imm"}, if1.imm, g.imm);
        chk({tag, ".data_1"}, if1.data_1, g.d1);
        chk({tag, ".data_2"}, if1.data_2, g.d2);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bub = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 3'b000, 2'b00);
    rst0 = 1'b1; rst1 = 1'b1;
    if0.if_valid = 1'b0; if0.pc = 32'd0; if0.inst_in = 32'd0; if0.reg_write = 1'b0;
    if0.write_register = 5'd0; if0.write_data_reg = 32'd0;
    if0.mem_reg_write = 1'b0; if0.mem_write_register = 5'd0;
    if1.if_valid = 1'b0; if1.pc = 64'd0; if1.inst_in = 32'd0; if1.reg_write = 1'b0;
    if1.write_register = 4'd0; if1.write_data_reg = 64'd0;
    if1.mem_reg_write = 1'b0; if1.mem_write_register = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state of both builds.
    chk("rst0.valid", 64'(if0.valid), 64'd0);
    chk("rst0.ctrl", 64'({if0.ex, if0.m, if0.wb}), 64'd0);
    chk("rst0.data_1", 64'(if0.data_1), 64'd0);
    chk("rst0.stall", 64'(if0.stall), 64'd0);
    chk("rst1.valid", 64'(if1.valid), 64'd0);
    chk("rst1.imm", if1.imm, 64'd0);
    rst1 = 1'b0;

    // WB bypass into a decoding add, then a write to r0 that must not stick.
    step(0, "s1", 1'b0, 1'b1, 64'h0, r_op(5'd5, 5'd6, 5'd1), 1'b1, 5'd5, DB, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd5, 5'd6, 5'd1, 64'h820, DB, 64'd0, 4'b1100, 3'b000, 2'b10));
    step(0, "s2", 1'b0, 1'b1, 64'h0, r_op(5'd0, 5'd5, 5'd2), 1'b1, 5'd0, 64'h12345678, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd0, 5'd5, 5'd2, 64'h1020, 64'd0, DB, 4'b1100, 3'b000, 2'b10));
    // Load-use: lw r2 then add r4,r2,r2 -> one stall cycle, one bubble.
    step(0, "s3", 1'b0, 1'b1, 64'h0, i_op(OP_LW, 5'd3, 5'd2, 16'h0000), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd3, 5'd2, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0001, 3'b010, 2'b11));
    step(0, "s4", 1'b0, 1'b1, 64'h0, r_op(5'd2, 5'd2, 5'd4), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b1, 1'b0, 64'd0, 1'b0, bub);
    step(0, "s5", 1'b0, 1'b1, 64'h0, r_op(5'd2, 5'd2, 5'd4), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd2, 5'd2, 5'd4, 64'h2020, 64'd0, 64'd0, 4'b1100, 3'b000, 2'b10));
    // Taken beq with negative offset, then a jump.
    step(0, "s6", 1'b0, 1'b1, 64'h100, i_op(OP_BEQ, 5'd1, 5'd1, 16'hFFFF), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b1, 64'hFC, 1'b0, mk(1'b1, 1'b1, 5'd1, 5'd1, 5'd31, 64'hFFFFFFFF, 64'd0, 64'd0, 4'b0010, 3'b100, 2'b00));
    step(0, "s7", 1'b0, 1'b1, 64'h30000104, {OP_J, 26'h0000040}, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b1, 64'h30000100, 1'b0, mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 64'h40, 64'd0, 64'd0, 4'b0000, 3'b000, 2'b00));
    // Branch hazard: add r7 in EX, beq r7,r5 stalls twice, resolves on WB bypass.
    step(0, "s8", 1'b0, 1'b1, 64'h200, r_op(5'd1, 5'd2, 5'd7), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd1, 5'd2, 5'd7, 64'h3820, 64'd0, 64'd0, 4'b1100, 3'b000, 2'b10));
    step(0, "s9", 1'b0, 1'b1, 64'h200, i_op(OP_BEQ, 5'd7, 5'd5, 16'h0004), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b1, 1'b0, 64'd0, 1'b0, bub);
    step(0, "s10", 1'b0, 1'b1, 64'h200, i_op(OP_BEQ, 5'd7, 5'd5, 16'h0004), 1'b0, 5'd0, 64'd0, 1'b1, 5'd7,
         1'b1, 1'b0, 64'd0, 1'b0, bub);
    step(0, "s11", 1'b0, 1'b1, 64'h200, i_op(OP_BEQ, 5'd7, 5'd5, 16'h0004), 1'b1, 5'd7, DB, 1'b0, 5'd0,
         1'b0, 1'b1, 64'h210, 1'b0, mk(1'b1, 1'b1, 5'd7, 5'd5, 5'd0, 64'h4, DB, DB, 4'b0010, 3'b100, 2'b00));
    // Unknown opcode with and without a valid slot.
    step(0, "s12", 1'b0, 1'b1, 64'h0, {6'b111111, 26'h0}, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b1, mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 3'b000, 2'b00));
    step(0, "s13", 1'b0, 1'b0, 64'h0, {6'b111111, 26'h0}, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, bub);
    // Reset during a load-use stall with a WB write pending.
    step(0, "s14", 1'b0, 1'b1, 64'h0, i_op(OP_LW, 5'd3, 5'd2, 16'h0000), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd3, 5'd2, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0001, 3'b010, 2'b11));
    step(0, "s15", 1'b1, 1'b1, 64'h0, r_op(5'd2, 5'd2, 5'd4), 1'b1, 5'd9, 64'hAAAA5555, 1'b0, 5'd0,
         1'b1, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 3'b000, 2'b00));
    step(0, "s16", 1'b0, 1'b1, 64'h0, r_op(5'd9, 5'd5, 5'd10), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd9, 5'd5, 5'd10, 64'h5020, 64'd0, 64'd0, 4'b1100, 3'b000, 2'b10));
    if0.if_valid = 1'b0;

    // 16 x 64-bit build with zero-extended immediates.
    step(1, "d1", 1'b0, 1'b1, 64'h0, r_op(5'd5, 5'd6, 5'd1), 1'b1, 5'd5, DB64, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd5, 5'd6, 5'd1, 64'h820, DB64, 64'd0, 4'b1100, 3'b000, 2'b10));
    step(1, "d2", 1'b0, 1'b1, 64'h100, i_op(OP_BEQ, 5'd2, 5'd2, 16'hFFFF), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b1, 64'h400FC, 1'b0, mk(1'b1, 1'b1, 5'd2, 5'd2, 5'd15, 64'hFFFF, 64'd0, 64'd0, 4'b0010, 3'b100, 2'b00));
    step(1, "d3", 1'b0, 1'b1, 64'h0, r_op(5'd5, 5'd21, 5'd3), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd3, 64'h1820, DB64, DB64, 4'b1100, 3'b000, 2'b10));
    step(1, "d4", 1'b1, 1'b1, 64'h0, r_op(5'd5, 5'd6, 5'd4), 1'b1, 5'd6, 64'h1111, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 3'b000, 2'b00));
    step(1, "d5", 1'b0, 1'b1, 64'h0, r_op(5'd5, 5'd6, 5'd4), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
         1'b0, 1'b0, 64'd0, 1'b0, mk(1'b1, 1'b1, 5'd5, 5'd6, 5'd4, 64'h2020, 64'd0, 64'd0, 4'b1100, 3'b000, 2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
